// File: rtl/video_linebuf_if.sv
// Renderer-side handshake and write port of the video line buffer.
interface video_linebuf_if #(
    parameter int unsigned DATA_W = 6
) ();
    logic              render_start;
    logic [7:0]        render_line;
    logic [7:0]        req_line;
    logic              req_valid;
    logic              wr_en;
    logic [7:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;

    modport master (
        output render_start, render_line, wr_en, wr_idx, wr_data, wr_done,
        input  req_line, req_valid
    );

    modport slave (
        input  render_start, render_line, wr_en, wr_idx, wr_data, wr_done,
        output req_line, req_valid
    );
endinterface

// File: rtl/video_linebuf.sv
// Double-buffered scanline buffer: renderer fills one bank while the other is scanned out.
// Optional macro VIDEO_LINEBUF_UNDERRUN_REPEAT_EN keeps the read bank on an underrun swap.
module video_linebuf #(
    parameter int unsigned DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    video_linebuf_if.slave    bus,
    input  logic              i_next_line,
    input  logic [7:0]        i_hpos,
    input  logic              i_border,
    input  logic              i_blank,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic [DATA_W-1:0] i_border_color,
    input  logic              i_underrun_clr,
    output logic [DATA_W-1:0] o_pix,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_underrun
);

    typedef enum logic [1:0] {StIdle, StRender, StDone} state_e;

    state_e            r_state, w_state_d;
    logic              r_rd_bank;
    logic              w_swap;
    logic              w_underrun_set;
    logic              r_req_valid, w_req_valid_d;
    logic [7:0]        r_req_line, w_req_line_d;
    logic              r_underrun;

    logic [DATA_W-1:0] r_mem [512];
    logic [DATA_W-1:0] r_ram_q;
    logic              r_blank_q, r_border_q, r_hsync_q, r_vsync_q;
    logic [DATA_W-1:0] r_border_color_q;
    logic [DATA_W-1:0] r_pix;
    logic              r_hsync_out, r_vsync_out;

    // next_line is resolved first so a same-cycle render_start sees the post-swap state.
    always_comb begin
        w_state_d      = r_state;
        w_req_valid_d  = r_req_valid;
        w_req_line_d   = r_req_line;
        w_swap         = 1'b0;
        w_underrun_set = 1'b0;
        if (i_next_line) begin
            w_swap        = 1'b1;
            w_state_d     = StIdle;
            w_req_valid_d = 1'b0;
            if (r_state == StRender) begin
                w_underrun_set = 1'b1;
`ifdef VIDEO_LINEBUF_UNDERRUN_REPEAT_EN
                w_swap = 1'b0;
`else
                w_swap = 1'b1;
`endif
            end
        end else if (r_state == StRender && bus.wr_done) begin
            w_state_d     = StDone;
            w_req_valid_d = 1'b0;
        end
        if (w_state_d == StIdle && bus.render_start) begin
            w_state_d     = StRender;
            w_req_line_d  = bus.render_line;
            w_req_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_rd_bank   <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_line  <= 8'd0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_rd_bank   <= r_rd_bank ^ w_swap;
            r_req_valid <= w_req_valid_d;
            r_req_line  <= w_req_line_d;
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (i_underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Line RAM is not reset; write uses the pre-swap bank even on a next_line cycle.
    always_ff @(posedge clk) begin
        if (bus.wr_en && r_state != StIdle) begin
            r_mem[{~r_rd_bank, bus.wr_idx}] <= bus.wr_data;
        end
        r_ram_q <= r_mem[{r_rd_bank, i_hpos}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank_q        <= 1'b0;
            r_border_q       <= 1'b0;
            r_hsync_q        <= 1'b1;
            r_vsync_q        <= 1'b1;
            r_border_color_q <= '0;
            r_pix            <= '0;
            r_hsync_out      <= 1'b1;
            r_vsync_out      <= 1'b1;
        end else begin
            r_blank_q        <= i_blank;
            r_border_q       <= i_border;
            r_hsync_q        <= i_hsync;
            r_vsync_q        <= i_vsync;
            r_border_color_q <= i_border_color;
            r_hsync_out      <= r_hsync_q;
            r_vsync_out      <= r_vsync_q;
            if (r_blank_q) begin
                r_pix <= '0;
            end else if (r_border_q) begin
                r_pix <= r_border_color_q;
            end else begin
                r_pix <= r_ram_q;
            end
        end
    end

    assign bus.req_line  = r_req_line;
    assign bus.req_valid = r_req_valid;
    assign o_pix         = r_pix;
    assign o_hsync       = r_hsync_out;
    assign o_vsync       = r_vsync_out;
    assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_video_linebuf.sv
// Directed testbench for video_linebuf: render/scan-out, border/blank, underrun, reset.
module tb_video_linebuf;

    logic       clk;
    logic       rst_n;
    logic       next_line;
    logic [7:0] hpos;
    logic       border;
    logic       blank;
    logic       hsync;
    logic       vsync;
    logic [5:0] border_color;
    logic       underrun_clr;
    logic [5:0] pix;
    logic       hsync_out;
    logic       vsync_out;
    logic       underrun;

    int n_pass;
    int n_total;

    video_linebuf_if #(.DATA_W(6)) bus ();

    video_linebuf #(.DATA_W(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .i_next_line    (next_line),
        .i_hpos         (hpos),
        .i_border       (border),
        .i_blank        (blank),
        .i_hsync        (hsync),
        .i_vsync        (vsync),
        .i_border_color (border_color),
        .i_underrun_clr (underrun_clr),
        .o_pix          (pix),
        .o_hsync        (hsync_out),
        .o_vsync        (vsync_out),
        .o_underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_render(input logic [7:0] line);
        bus.render_start = 1'b1;
        bus.render_line  = line;
        tick();
        bus.render_start = 1'b0;
    endtask

    task automatic pulse_next_line();
        next_line = 1'b1;
        tick();
        next_line = 1'b0;
    endtask

    task automatic write_px(input logic [7:0] idx, input logic [5:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = idx;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_total++;
        if (pix !== 6'h00) $display("FAIL reset_pix got=%h exp=00", pix); else n_pass++;
        n_total++;
        if (hsync_out !== 1'b1) $display("FAIL reset_hsync got=%b exp=1", hsync_out); else n_pass++;
        n_total++;
        if (vsync_out !== 1'b1) $display("FAIL reset_vsync got=%b exp=1", vsync_out); else n_pass++;
        n_total++;
        if (underrun !== 1'b0) $display("FAIL reset_underrun got=%b exp=0", underrun); else n_pass++;
        n_total++;
        if (bus.req_valid !== 1'b0)
            $display("FAIL reset_req_valid got=%b exp=0", bus.req_valid);
        else n_pass++;
        n_total++;
        if (bus.req_line !== 8'd0) $display("FAIL reset_req_line got=%0d exp=0", bus.req_line);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_render_sweep();
        logic [7:0] idx;
        pulse_render(8'd5);
        n_total++;
        if (bus.req_valid !== 1'b1) $display("FAIL start_req_valid got=%b exp=1", bus.req_valid);
        else n_pass++;
        for (int i = 0; i < 256; i++) begin
            idx = 8'(i);
            write_px(idx, idx[5:0]);
        end
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        n_total++;
        if (bus.req_valid !== 1'b0) $display("FAIL done_req_valid got=%b exp=0", bus.req_valid);
        else n_pass++;
        pulse_next_line();
        n_total++;
        if (bus.req_line !== 8'd5) $display("FAIL req_line got=%0d exp=5", bus.req_line);
        else n_pass++;
        // Output sampled after an hpos change reflects the hpos from one step earlier.
        for (int i = 0; i <= 256; i++) begin
            hpos = 8'(i);
            tick();
            if (i >= 1) begin
                idx = 8'(i - 1);
                n_total++;
                if (pix !== idx[5:0])
                    $display("FAIL sweep_pix hpos=%0d got=%h exp=%h", i - 1, pix, idx[5:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_border_blank();
        border       = 1'b1;
        border_color = 6'h2A;
        hpos         = 8'd10;
        hsync        = 1'b0;
        vsync        = 1'b0;
        tick();
        n_total++;
        if (hsync_out !== 1'b1) $display("FAIL hsync_early got=%b exp=1", hsync_out); else n_pass++;
        hsync = 1'b1;
        vsync = 1'b1;
        tick();
        n_total++;
        if (pix !== 6'h2A) $display("FAIL border_pix got=%h exp=2a", pix); else n_pass++;
        n_total++;
        if (hsync_out !== 1'b0) $display("FAIL hsync_lat got=%b exp=0", hsync_out); else n_pass++;
        n_total++;
        if (vsync_out !== 1'b0) $display("FAIL vsync_lat got=%b exp=0", vsync_out); else n_pass++;
        blank = 1'b1;
        tick();
        tick();
        n_total++;
        if (pix !== 6'h00) $display("FAIL blank_pix got=%h exp=00", pix); else n_pass++;
        blank  = 1'b0;
        border = 1'b0;
        tick();
        tick();
        n_total++;
        if (hsync_out !== 1'b1) $display("FAIL hsync_restore got=%b exp=1", hsync_out);
        else n_pass++;
    endtask

    task automatic test_underrun();
        logic [5:0] exp_px;
        pulse_render(8'd6);
        write_px(8'd20, 6'h11);
        write_px(8'd7, 6'h01);
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        pulse_next_line();
        hpos = 8'd20;
        tick();
        tick();
        n_total++;
        if (pix !== 6'h11) $display("FAIL bank0_pix got=%h exp=11", pix); else n_pass++;
        pulse_render(8'd7);
        write_px(8'd20, 6'h22);
        next_line    = 1'b1;
        underrun_clr = 1'b1;
        tick();
        next_line    = 1'b0;
        underrun_clr = 1'b0;
        n_total++;
        if (underrun !== 1'b1) $display("FAIL underrun_set got=%b exp=1", underrun); else n_pass++;
        n_total++;
        if (bus.req_valid !== 1'b0)
            $display("FAIL underrun_req_valid got=%b exp=0", bus.req_valid);
        else n_pass++;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        n_total++;
        if (underrun !== 1'b0) $display("FAIL underrun_clr got=%b exp=0", underrun); else n_pass++;
        tick();
`ifdef VIDEO_LINEBUF_UNDERRUN_REPEAT_EN
        exp_px = 6'h11;
`else
        exp_px = 6'h22;
`endif
        n_total++;
        if (pix !== exp_px) $display("FAIL underrun_bank got=%h exp=%h", pix, exp_px);
        else n_pass++;
        pulse_render(8'd8);
        n_total++;
        if (bus.req_valid !== 1'b1 || bus.req_line !== 8'd8)
            $display("FAIL idle_after_underrun got=%b/%0d exp=1/8", bus.req_valid, bus.req_line);
        else n_pass++;
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        pulse_next_line();
    endtask

    task automatic test_coincident_write();
        pulse_render(8'd9);
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 8'd7;
        bus.wr_data = 6'h3F;
        pulse_next_line();
        bus.wr_en = 1'b0;
        hpos = 8'd7;
        tick();
        tick();
        n_total++;
        if (pix !== 6'h3F) $display("FAIL coincident_write got=%h exp=3f", pix); else n_pass++;
        n_total++;
        if (underrun !== 1'b0) $display("FAIL no_underrun got=%b exp=0", underrun); else n_pass++;
    endtask

    task automatic test_midline_reset();
        pulse_render(8'd10);
        pulse_next_line();
        n_total++;
        if (underrun !== 1'b1) $display("FAIL pre_reset_underrun got=%b exp=1", underrun);
        else n_pass++;
        pulse_render(8'd9);
        border       = 1'b1;
        border_color = 6'h2A;
        hsync        = 1'b0;
        vsync        = 1'b0;
        tick();
        tick();
        n_total++;
        if (pix !== 6'h2A || hsync_out !== 1'b0)
            $display("FAIL pre_reset_out got=%h/%b exp=2a/0", pix, hsync_out);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (pix !== 6'h00) $display("FAIL rst_pix got=%h exp=00", pix); else n_pass++;
        n_total++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1)
            $display("FAIL rst_sync got=%b%b exp=11", hsync_out, vsync_out);
        else n_pass++;
        n_total++;
        if (underrun !== 1'b0) $display("FAIL rst_underrun got=%b exp=0", underrun); else n_pass++;
        n_total++;
        if (bus.req_valid !== 1'b0 || bus.req_line !== 8'd0)
            $display("FAIL rst_req got=%b/%0d exp=0/0", bus.req_valid, bus.req_line);
        else n_pass++;
        border = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_render(8'd33);
        n_total++;
        if (bus.req_valid !== 1'b1 || bus.req_line !== 8'd33)
            $display("FAIL post_reset_start got=%b/%0d exp=1/33", bus.req_valid, bus.req_line);
        else n_pass++;
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        rst_n            = 1'b0;
        next_line        = 1'b0;
        hpos             = 8'd0;
        border           = 1'b0;
        blank            = 1'b0;
        hsync            = 1'b1;
        vsync            = 1'b1;
        border_color     = 6'h00;
        underrun_clr     = 1'b0;
        bus.render_start = 1'b0;
        bus.render_line  = 8'd0;
        bus.wr_en        = 1'b0;
        bus.wr_idx       = 8'd0;
        bus.wr_data      = 6'h00;
        bus.wr_done      = 1'b0;

        test_reset();
        test_render_sweep();
        test_border_blank();
        test_underrun();
        test_coincident_write();
        test_midline_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
